// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester. Turns a valid/ready command stream
// into APB SETUP/ACCESS transfers and returns one response per command.
`timescale 1ns/1ps
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int RD_LATE    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic w_accept;
    logic w_done;
    logic w_timeout;
    logic w_late_rd;

    // Handshakes: a command transfers on the edge where cmd_valid && cmd_ready,
    // a response on the edge where rsp_valid && rsp_ready; payloads hold while valid is high.
    assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
    assign w_done    = (r_state == ST_ACCESS) && pready;
    assign w_timeout = (TIMEOUT != 0) && (r_state == ST_ACCESS) && !pready && (r_cnt == CNT_LAST);
    assign w_late_rd = (RD_LATE != 0) && !r_pwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    w_next = w_late_rd ? ST_CAPTURE : ST_RESP;
                end else if (w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // cmd_ready is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        case (r_state)
            ST_IDLE:   cmd_ready = rst_n;
            ST_SETUP:  psel = 1'b1;
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            ST_RESP:   rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
                r_rdata  <= '0;
                r_err    <= 1'b0;
                r_cnt    <= '0;
            end
            if (w_done) begin
                r_err <= pslverr;
                if (!r_pwrite && !pslverr && (RD_LATE == 0)) r_rdata <= prdata;
            end else if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Registered-read completers present data the cycle after ACCESS.
            if ((r_state == ST_CAPTURE) && !r_err) r_rdata <= prdata;
        end
    end

    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: drives two apb_master instances (RD_LATE=0 and RD_LATE=1) against a
// word-addressed completer memory and checks responses against a transaction-level model.
`timescale 1ns/1ps
module tb_apb_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          sel       = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] prdata    = '0;
    logic          pready    = 1'b0;
    logic          pslverr   = 1'b0;

    logic          cmd_ready_a, rsp_valid_a, rsp_err_a, psel_a, penable_a, pwrite_a;
    logic [DW-1:0] rsp_rdata_a, pwdata_a;
    logic [AW-1:0] paddr_a;
    logic          cmd_ready_b, rsp_valid_b, rsp_err_b, psel_b, penable_b, pwrite_b;
    logic [DW-1:0] rsp_rdata_b, pwdata_b;
    logic [AW-1:0] paddr_b;

    logic          cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
    logic [DW-1:0] rsp_rdata, pwdata;
    logic [AW-1:0] paddr;

    logic [DW-1:0] mem [0:15];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .RD_LATE(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .psel(psel_a), .penable(penable_a), .pwrite(pwrite_a), .paddr(paddr_a), .pwdata(pwdata_a),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .RD_LATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready & sel), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .psel(psel_b), .penable(penable_b), .pwrite(pwrite_b), .paddr(paddr_b), .pwdata(pwdata_b),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    assign cmd_ready = sel ? cmd_ready_b : cmd_ready_a;
    assign rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign rsp_err   = sel ? rsp_err_b   : rsp_err_a;
    assign rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
    assign psel      = sel ? psel_b      : psel_a;
    assign penable   = sel ? penable_b   : penable_a;
    assign pwrite    = sel ? pwrite_b    : pwrite_a;
    assign paddr     = sel ? paddr_b     : paddr_a;
    assign pwdata    = sel ? pwdata_b    : pwdata_a;

    // Transaction-level expectation: wait count decides timeout, then error, then data.
    task automatic model(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic err, input logic late_inst,
                         output logic [DW-1:0] er, output logic ee, output int eacc, output int elat);
        logic to;
        to   = (waits >= TMO);
        eacc = to ? TMO : waits + 1;
        ee   = to || err;
        er   = (w || ee) ? '0 : mem[a[5:2]];
        elat = 1 + eacc + ((late_inst && !w && !to) ? 1 : 0) + 1;
        if (w && !ee) mem[a[5:2]] = d;
    endtask

    // Command driver plus completer: returns the response, ACCESS length, latency and a bus-rules flag.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic err, input int hold,
                        output logic [DW-1:0] rdata, output logic rerr,
                        output int acc, output int lat, output logic ok);
        logic late;
        logic late_pending;
        ok = 1'b1; acc = 0; late = sel && !w; late_pending = 1'b0;
        @(negedge clk);
        if (cmd_ready !== 1'b1) ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 60) begin
            pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
            if (lat == 1 && !(psel === 1'b1 && penable === 1'b0)) ok = 1'b0;
            if (psel === 1'b1 && (paddr !== a || pwrite !== w || (w && pwdata !== d))) ok = 1'b0;
            if (psel !== 1'b1 && penable !== 1'b0) ok = 1'b0;
            if (cmd_ready !== 1'b0) ok = 1'b0;
            if (psel === 1'b1 && penable === 1'b1) begin
                if (acc >= waits) begin
                    pready = 1'b1; pslverr = err;
                    if (!late && !w) prdata = mem[a[5:2]];
                    late_pending = late;
                end
                acc++;
            end else if (late_pending) begin
                prdata = mem[a[5:2]];
                late_pending = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        pready = 1'b0; pslverr = 1'b0;
        if (rsp_valid !== 1'b1) ok = 1'b0;
        if (psel !== 1'b0 || penable !== 1'b0) ok = 1'b0;
        rdata = rsp_rdata; rerr = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== rerr || cmd_ready !== 1'b0) ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if ({psel_a, penable_a, pwrite_a, rsp_valid_a, rsp_err_a, cmd_ready_a} !== 6'b0)
            $display("FAIL reset_ctrl_a: got %b expected 000000", {psel_a, penable_a, pwrite_a, rsp_valid_a, rsp_err_a, cmd_ready_a});
        else n_pass++;
        n_total++;
        if ({psel_b, penable_b, rsp_valid_b, cmd_ready_b} !== 4'b0 || paddr_a !== '0 || pwdata_a !== '0 || rsp_rdata_a !== '0)
            $display("FAIL reset_data: paddr %h pwdata %h rdata %h ctrl_b %b expected all 0", paddr_a, pwdata_a, rsp_rdata_a, {psel_b, penable_b, rsp_valid_b, cmd_ready_b});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (cmd_ready_a !== 1'b1 || cmd_ready_b !== 1'b1)
            $display("FAIL reset_release_ready: got %b%b expected 11", cmd_ready_a, cmd_ready_b);
        else n_pass++;
    endtask

    task automatic test_write();
        logic [DW-1:0] r; logic e; int acc; int lat; logic ok;
        sel = 1'b0;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 0, r, e, acc, lat, ok);
        mem[4] = 32'hDEADBEEF;
        n_total++;
        if ({e, r} !== {1'b0, 32'h0}) $display("FAIL write_rsp: got err %b rdata %h expected 0 00000000", e, r); else n_pass++;
        n_total++;
        if (lat !== 3 || acc !== 1) $display("FAIL write_latency: got lat %0d acc %0d expected 3 1", lat, acc); else n_pass++;
        n_total++;
        if (ok !== 1'b1) $display("FAIL write_bus: got %b expected 1", ok); else n_pass++;
    endtask

    task automatic test_late_read();
        logic [DW-1:0] r; logic e; int acc; int lat; logic ok;
        sel = 1'b1;
        xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, 0, r, e, acc, lat, ok);
        sel = 1'b0;
        n_total++;
        if (r !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL late_read_data: got %h err %b expected deadbeef 0", r, e); else n_pass++;
        n_total++;
        if (lat !== 4 || acc !== 1) $display("FAIL late_read_latency: got lat %0d acc %0d expected 4 1", lat, acc); else n_pass++;
        n_total++;
        if (ok !== 1'b1) $display("FAIL late_read_bus: got %b expected 1", ok); else n_pass++;
    endtask

    task automatic test_wait_read();
        logic [DW-1:0] r; logic e; int acc; int lat; logic ok;
        sel = 1'b0;
        mem[8] = 32'h1234;
        xfer(1'b0, 32'h20, 32'h0, 3, 1'b0, 0, r, e, acc, lat, ok);
        n_total++;
        if (r !== 32'h1234 || e !== 1'b0) $display("FAIL wait_read_data: got %h err %b expected 00001234 0", r, e); else n_pass++;
        n_total++;
        if (acc !== 4 || lat !== 6) $display("FAIL wait_read_access: got acc %0d lat %0d expected 4 6", acc, lat); else n_pass++;
        n_total++;
        if (ok !== 1'b1) $display("FAIL wait_read_stable: got %b expected 1", ok); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [DW-1:0] r; logic e; int acc; int lat; logic ok;
        sel = 1'b0;
        mem[12] = 32'hCAFEF00D;
        xfer(1'b0, 32'h30, 32'h0, 100, 1'b0, 0, r, e, acc, lat, ok);
        n_total++;
        if (acc !== TMO || lat !== TMO + 2) $display("FAIL timeout_cycles: got acc %0d lat %0d expected %0d %0d", acc, lat, TMO, TMO + 2); else n_pass++;
        n_total++;
        if (e !== 1'b1 || r !== '0) $display("FAIL timeout_rsp: got err %b rdata %h expected 1 00000000", e, r); else n_pass++;
        n_total++;
        if (ok !== 1'b1) $display("FAIL timeout_bus: got %b expected 1", ok); else n_pass++;
    endtask

    task automatic test_slverr();
        logic [DW-1:0] r; logic e; int acc; int lat; logic ok;
        sel = 1'b0;
        mem[5] = 32'hA5A55A5A;
        xfer(1'b0, 32'h14, 32'h0, 1, 1'b1, 5, r, e, acc, lat, ok);
        n_total++;
        if (e !== 1'b1 || r !== '0) $display("FAIL slverr_rsp: got err %b rdata %h expected 1 00000000", e, r); else n_pass++;
        n_total++;
        if (ok !== 1'b1) $display("FAIL slverr_hold: got %b expected 1", ok); else n_pass++;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h5555AAAA; pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({psel, penable} !== 2'b11) $display("FAIL reset_mid_access: got %b expected 11", {psel, penable}); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({psel, penable, rsp_valid} !== 3'b0 || paddr !== '0)
            $display("FAIL reset_mid_async: got ctrl %b paddr %h expected 000 00000000", {psel, penable, rsp_valid}, paddr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0) $display("FAIL reset_mid_release: got ready %b psel %b expected 1 0", cmd_ready, psel); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc_q[$];
        int spin;
        sel = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3C; cmd_wdata = 32'h0BADF00D;
        pready = 1'b1; pslverr = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready === 1'b1) acc_q.push_back(i);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        mem[15] = 32'h0BADF00D;
        spin = 0;
        while (cmd_ready !== 1'b1 && spin < 10) begin
            @(negedge clk);
            spin++;
        end
        rsp_ready = 1'b0; pready = 1'b0;
        n_total++;
        if (acc_q.size() !== 3) $display("FAIL b2b_count: got %0d expected 3", acc_q.size()); else n_pass++;
        n_total++;
        if (acc_q.size() < 3 || acc_q[1] - acc_q[0] !== 4 || acc_q[2] - acc_q[1] !== 4)
            $display("FAIL b2b_spacing: got %p expected '{0,4,8}", acc_q);
        else n_pass++;
    endtask

    task automatic test_random(input logic inst, input int n);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] er, r, d, exp_r;
        logic [AW-1:0] a;
        logic w, err, ee, e, ok;
        int waits, hold, eacc, elat, acc, lat, pick;
        sel = inst;
        for (int i = 0; i < n; i++) begin
            w = 1'(($urandom_range(0, 1)));
            a = AW'($urandom_range(0, 15)) << 2;
            d = $urandom;
            err = ($urandom_range(0, 7) == 0);
            pick = $urandom_range(0, 9);
            waits = (pick < 7) ? $urandom_range(0, 3) : (pick == 7) ? TMO - 1 : (pick == 8) ? TMO : 0;
            hold = $urandom_range(0, 2);
            model(w, a, d, waits, err, inst, er, ee, eacc, elat);
            exp_q.push_back(er);
            xfer(w, a, d, waits, err, hold, r, e, acc, lat, ok);
            exp_r = exp_q.pop_front();
            n_total++;
            if (r !== exp_r || e !== ee)
                $display("FAIL rand%0d_%0d_rsp: got %h err %b expected %h err %b", inst, i, r, e, exp_r, ee);
            else n_pass++;
            n_total++;
            if (acc !== eacc || lat !== elat || ok !== 1'b1)
                $display("FAIL rand%0d_%0d_timing: got acc %0d lat %0d ok %b expected %0d %0d 1", inst, i, acc, lat, ok, eacc, elat);
            else n_pass++;
        end
        sel = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        test_reset();
        test_write();
        test_late_read();
        test_wait_read();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_back_to_back();
        test_random(1'b0, 30);
        test_random(1'b1, 12);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
